maxnet_sequencer: RTL and testbench

Iteration controller and value-register bank for the 4-unit winner-take-all network. It loads four 5-bit fixed-point candidate values and drives them as x0..x3 into four parallel PU instances. It sequences each unit's mult_reg_en/add_reg_en, captures each unit's new_value/Zero_signal, and repeats until at most one candidate is non-zero. It then reports the winner index and value.

---
 rtl/maxnet_pkg.sv | 22 ++
 rtl/maxnet_winner_enc.sv | 31 +++
 rtl/maxnet_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_maxnet_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared widths, value type and FSM state type for the
// 4-unit winner-take-all sequencer (maxnet_sequencer, maxnet_winner_enc).
package maxnet_pkg;

  localparam int unsigned DATA_W  = 5;  // two's complement candidate width
  localparam int unsigned FRAC_W  = 3;  // fraction bits within DATA_W
  localparam int unsigned N_UNITS = 4;  // parallel PU instances
  localparam int unsigned IDX_W   = 2;  // winner index width
  localparam int unsigned NZ_W    = 3;  // count of surviving candidates, 0..N_UNITS

  typedef logic [DATA_W-1:0] value_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_ADD,
    ST_UPDATE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/maxnet_winner_enc.sv
// maxnet_winner_enc: combinational survivor encoder.
// Ports:
//   zflags    in  N_UNITS  per-unit zero flags (1 = candidate collapsed)
//   nz        out NZ_W     number of cleared zero flags (surviving candidates)
//   first_idx out IDX_W    index of the lowest surviving candidate, 0 if none
module maxnet_winner_enc
  import maxnet_pkg::*;
(
  input  logic [N_UNITS-1:0] zflags,
  output logic [NZ_W-1:0]    nz,
  output logic [IDX_W-1:0]   first_idx
);

  logic found;

  always_comb begin
    nz        = '0;
    first_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (!zflags[i]) begin
        nz = nz + NZ_W'(1);
        if (!found) begin
          first_idx = IDX_W'(i);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/maxnet_sequencer.sv
// maxnet_sequencer: iteration controller and candidate register bank for the
// 4-unit winner-take-all network. Loads four candidates, pulses the PU
// multiply/add register enables, captures PU results and zero flags, and
// repeats until at most one candidate survives; then reports the winner.
// Configuration macro: MAXNET_TIMEOUT_EN builds an iteration counter that
// stops the run after MAX_ITER iterations and raises timeout.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle run request, honoured only when idle
//   in0..in3              initial candidates, latched on accepted start
//   new_value0..3/zero0..3 per-PU result and Zero_signal
//   x0..x3                current candidate registers
//   mult_reg_en/add_reg_en PU stage register enables
//   busy, done            run in progress / one-cycle completion pulse
//   winner_valid/idx/value single survivor report
//   timeout               iteration cap ended the run
module maxnet_sequencer
  import maxnet_pkg::*;
#(
  parameter int unsigned MAX_ITER = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] in0,
  input  logic [4:0] in1,
  input  logic [4:0] in2,
  input  logic [4:0] in3,
  input  logic [4:0] new_value0,
  input  logic [4:0] new_value1,
  input  logic [4:0] new_value2,
  input  logic [4:0] new_value3,
  input  logic       zero0,
  input  logic       zero1,
  input  logic       zero2,
  input  logic       zero3,
  output logic [4:0] x0,
  output logic [4:0] x1,
  output logic [4:0] x2,
  output logic [4:0] x3,
  output logic       mult_reg_en,
  output logic       add_reg_en,
  output logic       busy,
  output logic       done,
  output logic       winner_valid,
  output logic [1:0] winner_idx,
  output logic [4:0] winner_value,
  output logic       timeout
);

  state_t               state_q, state_d;
  value_t               x_q [N_UNITS];
  value_t               x_d [N_UNITS];
  logic [N_UNITS-1:0]   zflag_q, zflag_d;
  logic                 winner_valid_q, winner_valid_d;
  logic [IDX_W-1:0]     winner_idx_q, winner_idx_d;
  value_t               winner_value_q, winner_value_d;

  value_t               in_v [N_UNITS];
  value_t               nv_v [N_UNITS];
  logic [N_UNITS-1:0]   zero_v;
  logic [NZ_W-1:0]      nz;
  logic [IDX_W-1:0]     first_idx;

`ifdef MAXNET_TIMEOUT_EN
  logic [3:0]           iter_q, iter_d;
  logic                 timeout_q, timeout_d;
`endif

  assign in_v[0] = in0;
  assign in_v[1] = in1;
  assign in_v[2] = in2;
  assign in_v[3] = in3;
  assign nv_v[0] = new_value0;
  assign nv_v[1] = new_value1;
  assign nv_v[2] = new_value2;
  assign nv_v[3] = new_value3;
  assign zero_v  = {zero3, zero2, zero1, zero0};

  maxnet_winner_enc u_winner_enc (
    .zflags    (zflag_q),
    .nz        (nz),
    .first_idx (first_idx)
  );

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    zflag_d        = zflag_q;
    winner_valid_d = winner_valid_q;
    winner_idx_d   = winner_idx_q;
    winner_value_d = winner_value_q;
`ifdef MAXNET_TIMEOUT_EN
    iter_d         = iter_q;
    timeout_d      = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d            = in_v;
          winner_valid_d = 1'b0;
          winner_idx_d   = '0;
          winner_value_d = '0;
`ifdef MAXNET_TIMEOUT_EN
          iter_d         = '0;
          timeout_d      = 1'b0;
`endif
          state_d        = ST_MULT;
        end
      end
      ST_MULT:   state_d = ST_ADD;
      ST_ADD:    state_d = ST_UPDATE;
      ST_UPDATE: begin
        x_d     = nv_v;
        zflag_d = zero_v;
`ifdef MAXNET_TIMEOUT_EN
        iter_d  = iter_q + 4'd1;
`endif
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // Winner registers load on the CHECK->DONE edge so they are already
        // valid while done is high; zflags and x are frozen from here on.
        if (nz <= NZ_W'(1)) begin
          winner_valid_d = (nz == NZ_W'(1));
          winner_idx_d   = (nz == NZ_W'(1)) ? first_idx : '0;
          winner_value_d = (nz == NZ_W'(1)) ? x_q[first_idx] : '0;
          state_d        = ST_DONE;
        end
`ifdef MAXNET_TIMEOUT_EN
        else if (iter_q == 4'(MAX_ITER)) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
`endif
        else begin
          state_d = ST_MULT;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      for (int unsigned i = 0; i < N_UNITS; i++) x_q[i] <= '0;
      zflag_q        <= '1;
      winner_valid_q <= 1'b0;
      winner_idx_q   <= '0;
      winner_value_q <= '0;
`ifdef MAXNET_TIMEOUT_EN
      iter_q         <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      zflag_q        <= zflag_d;
      winner_valid_q <= winner_valid_d;
      winner_idx_q   <= winner_idx_d;
      winner_value_q <= winner_value_d;
`ifdef MAXNET_TIMEOUT_EN
      iter_q         <= iter_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign x0           = x_q[0];
  assign x1           = x_q[1];
  assign x2           = x_q[2];
  assign x3           = x_q[3];
  assign mult_reg_en  = (state_q == ST_MULT);
  assign add_reg_en   = (state_q == ST_ADD);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign winner_valid = winner_valid_q;
  assign winner_idx   = winner_idx_q;
  assign winner_value = winner_value_q;
`ifdef MAXNET_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Scoreboard bench for maxnet_sequencer: a PU stub replays a per-run script of
// results, a reference model predicts the outcome of each run, and a monitor
// checks every done pulse against the queued prediction.
module tb_maxnet_sequencer;

  localparam int unsigned MAXI = 3;
`ifdef MAXNET_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [4:0] nv0 = '0, nv1 = '0, nv2 = '0, nv3 = '0;
  logic       zero0 = 1'b1, zero1 = 1'b1, zero2 = 1'b1, zero3 = 1'b1;
  logic [4:0] x0, x1, x2, x3;
  logic       mult_reg_en, add_reg_en, busy, done, winner_valid, timeout;
  logic [1:0] winner_idx;
  logic [4:0] winner_value;

  maxnet_sequencer #(.MAX_ITER(MAXI)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .new_value0(nv0), .new_value1(nv1), .new_value2(nv2), .new_value3(nv3),
    .zero0(zero0), .zero1(zero1), .zero2(zero2), .zero3(zero3),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .mult_reg_en(mult_reg_en), .add_reg_en(add_reg_en),
    .busy(busy), .done(done),
    .winner_valid(winner_valid), .winner_idx(winner_idx),
    .winner_value(winner_value), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic            valid;
    logic [1:0]      idx;
    logic [4:0]      value;
    logic            to;
    int unsigned     iters;
    int unsigned     t0;
    logic [3:0][4:0] x;
  } exp_t;

  exp_t sb[$];
  int unsigned ncomp = 0;
  int unsigned nfail = 0;
  int unsigned ndone = 0;

  // Script: PU result for iteration j (0-based); the last entry repeats.
  logic [4:0]  scr_val [16][4];
  logic        scr_z   [16][4];
  int unsigned scr_len = 1;
  logic [4:0]  cand [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ncomp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: walk the script one iteration at a time and stop on
  // the first iteration leaving at most one survivor, or at the cap.
  function automatic exp_t model();
    exp_t e;
    int unsigned j, nz, w;
    e = '0;
    for (int unsigned it = 1; it <= 64; it++) begin
      j  = (it <= scr_len) ? it - 1 : scr_len - 1;
      nz = 0;
      w  = 0;
      for (int i = 3; i >= 0; i--)
        if (!scr_z[j][i]) begin nz++; w = i; end
      e.iters = it;
      for (int i = 0; i < 4; i++) e.x[i] = scr_val[j][i];
      if (nz <= 1) begin
        e.valid = (nz == 1);
        if (nz == 1) begin
          e.idx   = 2'(w);
          e.value = scr_val[j][w];
        end
        break;
      end
      if (TO_EN && it == MAXI) begin
        e.to = 1'b1;
        break;
      end
    end
    return e;
  endfunction

  // PU stub: results appear in the UPDATE cycle (the cycle after add_reg_en).
  int unsigned stub_it = 0;
  always @(negedge clk) begin
    int unsigned j;
    if (!busy) stub_it = 0;
    else if (add_reg_en) begin
      j = (stub_it < scr_len) ? stub_it : scr_len - 1;
      nv0 = scr_val[j][0]; nv1 = scr_val[j][1]; nv2 = scr_val[j][2]; nv3 = scr_val[j][3];
      zero0 = scr_z[j][0]; zero1 = scr_z[j][1]; zero2 = scr_z[j][2]; zero3 = scr_z[j][3];
      stub_it++;
    end
  end

  // Monitor: enable protocol plus scoreboard comparison on each done pulse.
  int unsigned mcnt = 0, acnt = 0;
  logic prev_m = 1'b0, prev_a = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (!busy) begin mcnt = 0; acnt = 0; end
    else begin
      if (mult_reg_en) mcnt++;
      if (add_reg_en) acnt++;
    end
    if ((mult_reg_en && add_reg_en) || (mult_reg_en && prev_m) || (add_reg_en && prev_a)) begin
      ncomp++; nfail++;
      $display("FAIL enable_protocol: mult=%0b add=%0b prev_mult=%0b prev_add=%0b", mult_reg_en, add_reg_en, prev_m, prev_a);
    end
    prev_m = mult_reg_en;
    prev_a = add_reg_en;
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        ncomp++; nfail++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        me = sb.pop_front();
        chk("winner_valid", 32'(winner_valid), 32'(me.valid));
        chk("winner_idx",   32'(winner_idx),   32'(me.idx));
        chk("winner_value", 32'(winner_value), 32'(me.value));
        chk("timeout",      32'(timeout),      32'(me.to));
        chk("run_length",   cyc - me.t0 + 1,   4 * me.iters + 1);
        chk("mult_pulses",  mcnt,              me.iters);
        chk("add_pulses",   acnt,              me.iters);
        chk("busy_at_done", 32'(busy),         32'd1);
        chk("x_at_done",    32'({x3, x2, x1, x0}), 32'(me.x));
      end
    end
  end

  task automatic set_step(input int unsigned j, input logic [4:0] v0, v1, v2, v3, input logic [3:0] z);
    scr_val[j][0] = v0; scr_val[j][1] = v1; scr_val[j][2] = v2; scr_val[j][3] = v3;
    for (int i = 0; i < 4; i++) scr_z[j][i] = z[i];
  endtask

  task automatic set_cand(input logic [4:0] a0, a1, a2, a3);
    cand[0] = a0; cand[1] = a1; cand[2] = a2; cand[3] = a3;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in0 = cand[0]; in1 = cand[1]; in2 = cand[2]; in3 = cand[3];
    start = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      ncomp++; nfail++;
      $display("FAIL done_wait: got no done expected done within 400 cycles");
      sb.delete();
      apply_reset();
    end
  endtask

  task automatic run_case(input bit poke);
    exp_t e;
    e = model();
    pulse_start();
    e.t0 = cyc + 1;
    sb.push_back(e);
    @(negedge clk); start = 1'b0;
    if (poke) begin
      for (int n = 0; n < 10 && !add_reg_en; n++) @(negedge clk);
      start = 1'b1;
      in0 = 5'h1f; in1 = 5'h1f; in2 = 5'h1f; in3 = 5'h1f;
      @(negedge clk); start = 1'b0;
    end
    drain();
  endtask

  task automatic rand_case();
    logic [4:0] cur [4];
    logic [4:0] v;
    int unsigned keep;
    set_cand(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int i = 0; i < 4; i++) cur[i] = cand[i];
    scr_len = $urandom_range(1, 6);
    keep = $urandom_range(0, 4);
    for (int unsigned j = 0; j < scr_len; j++)
      for (int unsigned i = 0; i < 4; i++) begin
        if (cur[i] == 0 || $urandom_range(0, 2) == 0 || (j == scr_len - 1 && i != keep))
          v = '0;
        else
          v = 5'($urandom_range(1, 31));
        cur[i] = v;
        scr_val[j][i] = v;
        scr_z[j][i] = (v == 0);
      end
    run_case(1'b0);
  endtask

  int unsigned done_before;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_x",     32'({x3, x2, x1, x0}), 32'd0);
    chk("reset_ctrl",  32'({mult_reg_en, add_reg_en, busy, done}), 32'd0);
    chk("reset_win",   32'({winner_valid, winner_idx, winner_value, timeout}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fast converge: one iteration, unit 0 survives.
    set_cand(5'b00010, 5'b00000, 5'b00000, 5'b00000);
    scr_len = 1;
    set_step(0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 4'b1110);
    run_case(1'b0);

    // Two iterations, start poked during ADD must be ignored.
    set_cand(5'b00010, 5'b11100, 5'b00100, 5'b00110);
    scr_len = 2;
    set_step(0, 5'b00000, 5'b00000, 5'b00010, 5'b00100, 4'b0011);
    set_step(1, 5'b00000, 5'b00000, 5'b00000, 5'b00011, 4'b0111);
    run_case(1'b1);

    // All collapse.
    set_cand(5'b00100, 5'b00100, 5'b00011, 5'b00001);
    scr_len = 1;
    set_step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'b1111);
    run_case(1'b0);

    // Never-converging stub: timeout, or unbounded running.
    set_cand(5'b00001, 5'b00010, 5'b00011, 5'b00100);
    scr_len = 1;
    set_step(0, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 4'b0000);
    if (TO_EN) run_case(1'b0);
    else begin
      done_before = ndone;
      pulse_start();
      @(negedge clk); start = 1'b0;
      repeat (200) @(negedge clk);
      chk("no_done_unbounded", ndone - done_before, 0);
      chk("busy_unbounded", 32'(busy), 32'd1);
      apply_reset();
    end

    // Reset abort during UPDATE.
    done_before = ndone;
    pulse_start();
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 10 && !add_reg_en; n++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_x",    32'({x3, x2, x1, x0}), 32'd0);
    chk("abort_ctrl", 32'({mult_reg_en, add_reg_en, busy, done}), 32'd0);
    chk("abort_win",  32'({winner_valid, winner_idx, winner_value, timeout}), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", ndone - done_before, 0);

    // Normal run after abort.
    set_cand(5'b00010, 5'b00000, 5'b00000, 5'b00000);
    scr_len = 1;
    set_step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00101, 4'b0111);
    run_case(1'b0);

    for (int r = 0; r < 25; r++) rand_case();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
